// File: rtl/env_int_timer.sv
// Multi-channel countdown timer on the Z80 I/O bus, raising INT/NMI stimulus.
// Bus writes are latched while strobed and committed on the strobe's trailing edge.
module env_int_timer #(
   parameter logic [7:0] BASE_ADDR = 8'hB0,
   parameter int         NUM_CH    = 2,
   parameter int         CNT_W     = 16,
   parameter int         PRESCALE  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [7:0] addr,
   input  logic [7:0] d_out,
   output logic [7:0] di,
   output logic       di_oe,
   output logic       int_n,
   output logic       nmi_n
);

   localparam int LAST_OFF = 3 + 4 * NUM_CH;
   localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   function automatic logic [8:0] offset_of(input logic [7:0] a);
      return {1'b0, a} - {1'b0, BASE_ADDR};
   endfunction

   logic              wr_stb, commit;
   logic              wr_stb_q, wr_stb_d;
   logic [7:0]        wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
   logic [8:0]        wr_o;
   logic              wr_hit, status_wr, gctrl_wr, ch_wr;
   logic [5:0]        wr_ch;
   logic [PW-1:0]     presc_q, presc_d;
   logic              tick;
   logic              int_en_q, int_en_d, nmi_en_q, nmi_en_d;
   logic [NUM_CH-1:0] pending_q, pending_d, w1c, set_vec, route_vec;
   logic              int_n_q, int_n_d, nmi_n_q, nmi_n_d;
   logic [NUM_CH-1:0][31:0] rd_words;
   logic [8:0]        rd_o;
   logic [5:0]        rd_ch;
   logic [31:0]       rd_word;

   assign wr_stb    = !iorq_n && !wr_n;
   assign commit    = wr_stb_q && !wr_stb;
   assign wr_o      = offset_of(wr_addr_q);
   assign wr_hit    = commit && !wr_o[8] && (wr_o[7:0] <= 8'(LAST_OFF));
   assign status_wr = wr_hit && (wr_o[7:0] == 8'd0);
   assign gctrl_wr  = wr_hit && (wr_o[7:0] == 8'd1);
   assign ch_wr     = wr_hit && (wr_o[7:0] >= 8'd4);
   assign wr_ch     = wr_o[7:2] - 6'd1;
   assign tick      = (presc_q == PW'(PRESCALE - 1));
   assign int_n     = int_n_q;
   assign nmi_n     = nmi_n_q;

   always_comb begin
      wr_stb_d  = wr_stb;
      wr_addr_d = wr_stb ? addr  : wr_addr_q;
      wr_data_d = wr_stb ? d_out : wr_data_q;
      presc_d   = tick ? '0 : presc_q + PW'(1);
      int_en_d  = int_en_q;
      nmi_en_d  = nmi_en_q;
      if (gctrl_wr) begin
         int_en_d = wr_data_q[0];
         nmi_en_d = wr_data_q[1];
      end
      // A hardware set in the same cycle as a W1C of that bit wins.
      w1c       = status_wr ? wr_data_q[NUM_CH-1:0] : '0;
      pending_d = (pending_q & ~w1c) | set_vec;
      int_n_d   = !(int_en_q && |(pending_q & ~route_vec));
      nmi_n_d   = !(nmi_en_q && |(pending_q & route_vec));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         presc_q   <= '0;
         int_en_q  <= 1'b0;
         nmi_en_q  <= 1'b0;
         pending_q <= '0;
         int_n_q   <= 1'b1;
         nmi_n_q   <= 1'b1;
      end else begin
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         presc_q   <= presc_d;
         int_en_q  <= int_en_d;
         nmi_en_q  <= nmi_en_d;
         pending_q <= pending_d;
         int_n_q   <= int_n_d;
         nmi_n_q   <= nmi_n_d;
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             en_q, en_d, per_q, per_d, rnmi_q, rnmi_d;
      logic [CNT_W-1:0] reload_q, reload_d, count_q, count_d;
      logic [15:0]      reload_ext, reload_tmp, force_val;
      logic             sel, set_hit;

      assign reload_ext = 16'(reload_q);

      always_comb begin
         reload_tmp = reload_ext;
         force_val  = {reload_ext[15:8], wr_data_q};
         sel        = ch_wr && (wr_ch == 6'(gi));
         en_d       = en_q;
         per_d      = per_q;
         rnmi_d     = rnmi_q;
         reload_d   = reload_q;
         count_d    = count_q;
         set_hit    = 1'b0;
         if (tick && en_q) begin
            if (count_q > CNT_W'(1)) begin
               count_d = count_q - CNT_W'(1);
            end else if (count_q == CNT_W'(1)) begin
               set_hit = 1'b1;
               if (per_q && (reload_q != '0)) begin
                  count_d = reload_q;
               end else begin
                  count_d = '0;
                  en_d    = 1'b0;
               end
            end
         end
         if (sel) begin
            case (wr_o[1:0])
               2'd0: begin
                  en_d   = wr_data_q[0];
                  per_d  = wr_data_q[1];
                  rnmi_d = wr_data_q[2];
                  if (wr_data_q[0] && (count_q == '0)) count_d = reload_q;
               end
               2'd1: begin
                  reload_tmp[7:0] = wr_data_q;
                  reload_d        = reload_tmp[CNT_W-1:0];
               end
               2'd2: begin
                  reload_tmp[15:8] = wr_data_q;
                  reload_d         = reload_tmp[CNT_W-1:0];
               end
               default: begin
                  // Force-load pre-empts the whole tick for this channel.
                  count_d = force_val[CNT_W-1:0];
                  en_d    = en_q;
                  set_hit = 1'b0;
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            en_q     <= 1'b0;
            per_q    <= 1'b0;
            rnmi_q   <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
         end else begin
            en_q     <= en_d;
            per_q    <= per_d;
            rnmi_q   <= rnmi_d;
            reload_q <= reload_d;
            count_q  <= count_d;
         end
      end

      assign set_vec[gi]   = set_hit;
      assign route_vec[gi] = rnmi_q;
      assign rd_words[gi]  = {count_q[7:0], reload_ext[15:8], reload_ext[7:0],
                              5'b0, rnmi_q, per_q, en_q};
   end

   always_comb begin
      rd_o    = offset_of(addr);
      rd_ch   = rd_o[7:2] - 6'd1;
      di_oe   = !iorq_n && !rd_n && !rd_o[8] && (rd_o[7:0] <= 8'(LAST_OFF));
      di      = 8'h00;
      rd_word = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch == 6'(c)) rd_word = rd_words[c];
      end
      if (di_oe) begin
         case (rd_o[7:0])
            8'd0:       di = 8'(pending_q);
            8'd1:       di = {6'b0, nmi_en_q, int_en_q};
            8'd2, 8'd3: di = 8'hFF;
            default: begin
               case (rd_o[1:0])
                  2'd0:    di = rd_word[7:0];
                  2'd1:    di = rd_word[15:8];
                  2'd2:    di = rd_word[23:16];
                  default: di = rd_word[31:24];
               endcase
            end
         endcase
      end
   end

endmodule

// File: doc/env_int_timer.md
Name: env_int_timer

Overview:
- Parametrised successor to the single-countdown interrupt/NMI stimulus logic in the test environment I/O block.
- Provides NUM_CH independent countdown channels on the Z80 I/O bus. Each channel has a reload value, one-shot or periodic mode, and INT or NMI routing.
- Sits in tb_top beside the environment I/O block and drives int_n/nmi_n of the TV80 instance. This gives programs periodic and multi-source interrupt stimulus.

Parameters:
- BASE_ADDR, 8'hB0: first I/O address of the register window.
- NUM_CH, 2: channel count, 1..8.
- CNT_W, 16: counter/reload width, 8..16.
- PRESCALE, 1: clk cycles per counter tick, at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- iorq_n  in  1  Z80 I/O request, active low.
- rd_n  in  1  Z80 read strobe, active low.
- wr_n  in  1  Z80 write strobe, active low.
- addr  in  8  I/O address (A[7:0]).
- d_out  in  8  CPU write data.
- di  out  8  read data, valid while di_oe=1, else 8'h00.
- di_oe  out  1  read-select; the top level muxes di onto the CPU data-in bus.
- int_n  out  1  maskable interrupt, active low, registered.
- nmi_n  out  1  NMI, active low, registered.

Behaviour:
- Register map, offsets from BASE_ADDR; window = BASE_ADDR .. BASE_ADDR+3+4*NUM_CH.
  - +0 STATUS: pending[NUM_CH-1:0]; write-1-to-clear.
  - +1 GCTRL: bit0 int_en, bit1 nmi_en.
  - +2, +3: read 8'hFF; writes ignored.
  - Channel c at +4+4c:
    - +0 CTRL: bit0 en, bit1 periodic, bit2 route_nmi.
    - +1 RELOAD[7:0].
    - +2 RELOAD[CNT_W-1:8], or reads 0 if CNT_W=8.
    - +3 COUNT[7:0]: read = live low byte; write = force-load full count from {RELOAD high, d_out}.
- Reset values: all registers, counters, pending and prescaler = 0; int_n=1, nmi_n=1, di_oe=0.
- Reads:
  - Combinational; di_oe = !iorq_n & !rd_n & addr in window.
  - Unused bits read 0; no read side effects.
- Writes:
  - wr_stb = !iorq_n & !wr_n.
  - addr and d_out are latched every cycle wr_stb=1.
  - Commit occurs in the first cycle wr_stb=0 after wr_stb=1 (trailing edge), using the latched values. Exactly one commit per strobe regardless of strobe length.
  - Writes outside the window are ignored.
- Prescaler:
  - Counts 0..PRESCALE-1; tick=1 in the cycle it equals PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- Channel counting, on tick with en=1:
  - COUNT>1: COUNT-1.
  - COUNT==1: COUNT becomes 0 and pending[c] is set. Then:
    - periodic=1 and RELOAD!=0: COUNT loads RELOAD in the same cycle.
    - periodic=1 and RELOAD==0: en clears.
    - periodic=0: en clears.
  - COUNT==0: no change.
- Writing CTRL with en=1 while COUNT==0 loads COUNT=RELOAD.
- Writing en=0 freezes COUNT; pending is kept.
- Outputs, registered, one cycle after the pending change:
  - int_n = !(int_en & |(pending & ~route_nmi)).
  - nmi_n = !(nmi_en & |(pending & route_nmi)).
- Simultaneous events:
  - Hardware pending set and W1C of the same bit in the same cycle: set wins.
  - Force-load COUNT write and tick in the same cycle: write wins, no decrement that cycle.
  - RELOAD write during a tick: the new value applies on the next reload only.
- Wrap: COUNT never underflows. Widths are truncated to CNT_W.
- Reset mid-operation clears everything within one cycle, including a half-completed write strobe (the latched write is discarded).

Test Plan:
1. Reset, then read STATUS, GCTRL, ch0 CTRL -> di=8'h00; int_n=nmi_n=1; read of BASE+2 -> 8'hFF with di_oe=1.
2. PRESCALE=1. ch0 RELOAD=5, one-shot, int_en=1, en=1 -> pending[0] and int_n=0 exactly 5 ticks (+1 register cycle) after commit. en reads 0 afterwards. Write STATUS=8'h01 -> int_n=1 next cycle.
3. ch1 periodic, RELOAD=3, route_nmi=1, nmi_en=1 -> pending[1] every 3 ticks. W1C between events toggles nmi_n. COUNT reads 3,2,1,3,... on successive ticks.
4. PRESCALE=4, ch0 RELOAD=2 -> pending after 8 clk cycles. Wr strobe held 5 cycles -> single commit on the trailing edge.
5. Time a W1C of pending[0] to coincide with a new ch0 expiry -> pending[0] stays 1. Force-load COUNT coinciding with a tick -> COUNT equals the written value.
6. Assert reset while ch0 is counting and mid write strobe -> all registers 0, int_n=1, no commit after reset releases.
